// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mux_pkg
// Brief   : Shared sizing helpers for the pipelined word multiplexer tree.
// Revision: 1.0 - initial release
// ============================================================================
package mux_pkg;

    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    function automatic int ceil_div_f(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int lat_f(input int num_in, input int stage_levels);
        return ceil_div_f(clog2_f(num_in), stage_levels);
    endfunction

    // The last stage resolves whatever select bits remain.
    function automatic int stage_lv_f(input int sel_w, input int stage_levels, input int s);
        int rem;
        rem = sel_w - s * stage_levels;
        return (rem < stage_levels) ? rem : stage_levels;
    endfunction

    function automatic int stage_n_f(input int num_in, input int stage_levels, input int s);
        int n;
        n = num_in;
        for (int i = 0; i < s; i++)
            n = ceil_div_f(n, 1 << stage_lv_f(clog2_f(num_in), stage_levels, i));
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_tree_stage.sv
`default_nettype none
// ============================================================================
// Module  : mux_tree_stage
// Brief   : LEVELS mux2 levels followed by a hold-enabled register stage.
// Revision: 1.0 - initial release
// ============================================================================
module mux_tree_stage
    import mux_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int N_IN   = 4,
    parameter int LEVELS = 2,
    parameter int SEL_W  = 2,
    localparam int FAN   = 1 << LEVELS,
    localparam int N_OUT = ceil_div_f(N_IN, FAN)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   in_valid,
    input  logic [N_IN*WIDTH-1:0]  in_words,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic [LEVELS-1:0]      level_sel,
    output logic                   out_valid,
    output logic [N_OUT*WIDTH-1:0] out_words,
    output logic [SEL_W-1:0]       out_sel
);

    logic [WIDTH-1:0]       w_pad [N_OUT][FAN];
    logic [N_OUT*WIDTH-1:0] w_mux;
    logic                   r_valid;
    logic [N_OUT*WIDTH-1:0] r_words;
    logic [SEL_W-1:0]       r_sel;

    // Missing inputs read as zero, which makes out-of-range selects yield 0.
    for (genvar j = 0; j < N_OUT; j++) begin : g_grp
        for (genvar k = 0; k < FAN; k++) begin : g_leg
            if (j * FAN + k < N_IN) begin : g_real
                assign w_pad[j][k] = in_words[(j*FAN+k)*WIDTH +: WIDTH];
            end else begin : g_zero
                assign w_pad[j][k] = '0;
            end
        end
        assign w_mux[j*WIDTH +: WIDTH] = w_pad[j][level_sel];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_words <= '0;
            r_sel   <= '0;
        end else if (en) begin
            r_valid <= in_valid;
            r_words <= w_mux;
            r_sel   <= in_sel;
        end
    end

    assign out_valid = r_valid;
    assign out_words = r_words;
    assign out_sel   = r_sel;

endmodule
`default_nettype wire

// File: rtl/mux_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module  : mux_tree_pipe
// Brief   : Pipelined NUM_IN:1 word mux with global-enable valid/ready stall.
// Revision: 1.0 - initial release
// ============================================================================
module mux_tree_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH        = 64,
    parameter int NUM_IN       = 32,
    parameter int STAGE_LEVELS = 2,
    localparam int SEL_W       = clog2_f(NUM_IN),
    localparam int LAT         = lat_f(NUM_IN, STAGE_LEVELS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel
);

    logic w_advance;

    // One enable for every stage: the whole pipe moves or the whole pipe holds.
    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;

    for (genvar s = 0; s < LAT; s++) begin : g_stage
        localparam int N_S  = stage_n_f(NUM_IN, STAGE_LEVELS, s);
        localparam int LV_S = stage_lv_f(SEL_W, STAGE_LEVELS, s);
        localparam int N_O  = ceil_div_f(N_S, 1 << LV_S);

        logic [N_S*WIDTH-1:0] stage_in;
        logic [SEL_W-1:0]     sel_in;
        logic                 valid_in;
        logic [N_O*WIDTH-1:0] stage_out;
        logic [SEL_W-1:0]     sel_out;
        logic                 valid_out;

        if (s == 0) begin : g_first
            assign stage_in = in_data;
            assign sel_in   = in_sel;
            assign valid_in = in_valid;
        end else begin : g_next
            assign stage_in = g_stage[s-1].stage_out;
            assign sel_in   = g_stage[s-1].sel_out;
            assign valid_in = g_stage[s-1].valid_out;
        end

        mux_tree_stage #(
            .WIDTH  (WIDTH),
            .N_IN   (N_S),
            .LEVELS (LV_S),
            .SEL_W  (SEL_W)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .en        (w_advance),
            .in_valid  (valid_in),
            .in_words  (stage_in),
            .in_sel    (sel_in),
            .level_sel (sel_in[s*STAGE_LEVELS +: LV_S]),
            .out_valid (valid_out),
            .out_words (stage_out),
            .out_sel   (sel_out)
        );
    end

    assign out_valid = g_stage[LAT-1].valid_out;
    assign out_data  = g_stage[LAT-1].stage_out;
    assign out_sel   = g_stage[LAT-1].sel_out;

endmodule
`default_nettype wire

// File: tb/tb_mux_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_mux_tree_pipe
// Brief   : Directed self-checking bench for mux_tree_pipe (32:1 and 20:1).
// Revision: 1.0 - initial release
// ============================================================================
module tb_mux_tree_pipe;
    import mux_pkg::*;

    localparam int W    = 64;
    localparam int N    = 32;
    localparam int N2   = 20;
    localparam int LAT  = lat_f(N, 2);

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid, in_ready, out_valid, out_ready;
    logic [N*W-1:0]  in_data;
    logic [4:0]      in_sel, out_sel;
    logic [W-1:0]    out_data;

    logic            b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [N2*W-1:0] b_in_data;
    logic [4:0]      b_in_sel, b_out_sel;
    logic [W-1:0]    b_out_data;

    int              checks = 0;
    int              errors = 0;
    int              pops;
    logic [4:0]      exp_q[$];
    logic            stalled_prev;
    logic [W-1:0]    held;

    always #5 clk = ~clk;

    mux_tree_pipe #(.WIDTH(W), .NUM_IN(N), .STAGE_LEVELS(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel)
    );

    mux_tree_pipe #(.WIDTH(W), .NUM_IN(N2), .STAGE_LEVELS(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_sel(b_in_sel), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_sel(b_out_sel)
    );

    function automatic logic [W-1:0] word(input int k);
        return 64'hA5A5_0000_0000_0000 | 64'(k);
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One handshake cycle against an in-order expectation queue.
    task automatic cycle(input logic v, input logic [4:0] s, input logic ordy, output logic acc);
        logic [4:0] e;
        in_valid  = v;
        in_sel    = s;
        out_ready = ordy;
        #1;
        chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
        if (stalled_prev) chk("stall_hold", out_data, held);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                pops++;
                chk("q_data", out_data, word(int'(e)));
                chk("q_sel", 64'(out_sel), 64'(e));
            end
        end
        stalled_prev = out_valid && !out_ready;
        held         = out_data;
        acc          = v && in_ready;
        if (acc) exp_q.push_back(s);
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc;
        int   nxt;

        for (int k = 0; k < N; k++)  in_data[k*W +: W]   = word(k);
        for (int k = 0; k < N2; k++) b_in_data[k*W +: W] = word(k);
        reset = 1'b1; in_valid = 1'b0; in_sel = '0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_sel = '0; b_out_ready = 1'b1;
        stalled_prev = 1'b0; held = '0; pops = 0;
        step(); step();
        reset = 1'b0;

        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_sel", 64'(out_sel), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Single request, latency LAT
        in_valid = 1'b1; in_sel = 5'd19;
        step();
        in_valid = 1'b0;
        chk("t1_lat_e0", 64'(out_valid), 64'd0);
        step();
        chk("t1_lat_e1", 64'(out_valid), 64'd0);
        step();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_data", out_data, 64'hA5A5_0000_0000_0013);
        chk("t1_sel", 64'(out_sel), 64'd19);
        step();
        chk("t1_one_cycle", 64'(out_valid), 64'd0);

        // Streaming at full throughput
        for (int c = 0; c < N + LAT - 1; c++) begin
            in_valid = (c < N);
            in_sel   = 5'(c);
            #1;
            chk("t2_in_ready", 64'(in_ready), 64'd1);
            step();
            if (c >= LAT - 1) begin
                chk("t2_valid", 64'(out_valid), 64'd1);
                chk("t2_data", out_data, word(c - (LAT - 1)));
            end
        end
        step();
        chk("t2_drained", 64'(out_valid), 64'd0);

        // Back-pressure: out_ready low for cycles 4..8
        nxt = 0; pops = 0; stalled_prev = 1'b0;
        for (int c = 0; c < 24; c++) begin
            cycle(nxt < 8, 5'(nxt), !(c >= 4 && c < 9), acc);
            if (acc) nxt++;
        end
        chk("t3_pops", 64'(pops), 64'd8);
        chk("t3_q_empty", 64'(exp_q.size()), 64'd0);

        // Reset with results in flight
        in_valid = 1'b1; out_ready = 1'b1;
        in_sel = 5'd3; step();
        in_sel = 5'd4; step();
        in_sel = 5'd5; step();
        in_valid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t4_flush_valid", 64'(out_valid), 64'd0);
        chk("t4_flush_data", out_data, 64'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t4_no_stale", 64'(out_valid), 64'd0);
        end
        in_valid = 1'b1; in_sel = 5'd7;
        step();
        in_valid = 1'b0;
        step();
        chk("t4_new_e1", 64'(out_valid), 64'd0);
        step();
        chk("t4_new_valid", 64'(out_valid), 64'd1);
        chk("t4_new_data", out_data, word(7));
        step();

        // Non-power-of-two instance: out-of-range and last real word
        b_in_valid = 1'b1; b_in_sel = 5'd25; step();
        b_in_sel = 5'd19; step();
        b_in_valid = 1'b0; step();
        chk("t5_oor_valid", 64'(b_out_valid), 64'd1);
        chk("t5_oor_data", b_out_data, 64'd0);
        chk("t5_oor_sel", 64'(b_out_sel), 64'd25);
        step();
        chk("t5_w19_data", b_out_data, word(19));
        chk("t5_w19_sel", 64'(b_out_sel), 64'd19);

        // Bubbles with random back-pressure
        pops = 0; stalled_prev = 1'b0; nxt = 0;
        for (int c = 0; c < 1000; c++) begin
            cycle(c % 2 == 0, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), acc);
            if (acc) nxt++;
        end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++)
            cycle(1'b0, 5'd0, 1'b1, acc);
        chk("t6_q_empty", 64'(exp_q.size()), 64'd0);
        chk("t6_count", 64'(pops), 64'(nxt));
        cycle(1'b0, 5'd0, 1'b1, acc);
        chk("t6_idle", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
